fifo_uart_tx: RTL

Serial transmit stage that drains the synchronous FIFO and drives a UART line. When enabled and the FIFO reports non-empty, it issues a single-cycle read strobe, captures the registered FIFO output word, and shifts it out as an asynchronous serial frame: start bit, W data bits LSB first, optional parity, one or two stop bits. It sits directly downstream of the FIFO: its `fifo_rd_en` drives the FIFO `rd_en`, its `fifo_empty` is the FIFO `EMPTY`, and its `fifo_data` is the FIFO `data_out`.

---
 rtl/fifo_uart_tx.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Serial transmit stage placed directly behind a synchronous FIFO. While
// enabled and the FIFO is non-empty, it issues a one-cycle read strobe, takes
// the registered FIFO word one cycle later and shifts it out as an
// asynchronous frame: start bit, W data bits LSB first, optional parity bit,
// then one or two stop bits.
//
// Parameters
//   W            data word width (equal to the FIFO width)
//   CLKS_PER_BIT clk cycles per serial bit (>= 2)
//   PARITY_EN    1 inserts a parity bit after the data bits
//   PARITY_ODD   0 even parity, 1 odd parity (unused when PARITY_EN = 0)
//   STOP_BITS    1 or 2 stop bits
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   enable      in   permits starting a new frame (looked at only in IDLE)
//   fifo_empty  in   FIFO EMPTY flag
//   fifo_data   in   FIFO registered read data, valid the cycle after the strobe
//   fifo_rd_en  out  registered read strobe, one cycle per frame
//   tx          out  registered serial line, idles high
//   busy        out  high whenever the block is not in IDLE
//   frame_done  out  one-cycle pulse after the final stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int W            = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         fifo_empty,
  input  logic [W-1:0] fifo_data,
  output logic         fifo_rd_en,
  output logic         tx,
  output logic         busy,
  output logic         frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(W + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);
  // One stop-bit counter step per stop bit; only two stop bits need a second.
  localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;
  localparam logic             ODD_FLIP  = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  // Parity of a data word; odd parity is the inverted XOR reduction.
  function automatic logic parity_of(input logic [W-1:0] d);
    parity_of = (^d) ^ ODD_FLIP;
  endfunction

  state_t           state_q, state_d;
  logic [W-1:0]     shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             stop_q, stop_d;
  logic             tx_q, tx_d;
  logic             rd_q, rd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             baud_end_s;
  logic [W-1:0]     shift_nxt_s;

  assign baud_end_s  = (baud_q == CNT_LAST);
  assign shift_nxt_s = shift_q >> 1;

  // Next-state and registered-output logic of the transmit FSM.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    tx_d     = tx_q;
    rd_d     = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (enable && !fifo_empty) begin
          state_d = FETCH;
          rd_d    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      // The FIFO presents the word at the end of this cycle.
      FETCH: begin
        state_d = LOAD;
      end

      LOAD: begin
        shift_d  = fifo_data;
        parity_d = parity_of(fifo_data);
        tx_d     = 1'b0;
        baud_d   = '0;
        bit_d    = '0;
        stop_d   = 1'b0;
        state_d  = START;
      end

      START: begin
        if (baud_end_s) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d  = baud_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (baud_end_s) begin
          baud_d  = '0;
          shift_d = shift_nxt_s;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              tx_d    = parity_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            // Next data bit is the LSB of the word after this shift.
            tx_d = shift_nxt_s[0];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      PARITY: begin
        if (baud_end_s) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          baud_d  = baud_q + CNT_W'(1);
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (baud_end_s) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            stop_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_d  = stop_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        baud_d  = '0;
        bit_d   = '0;
        stop_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      parity_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      tx_q     <= 1'b1;
      rd_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      tx_q     <= tx_d;
      rd_q     <= rd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign fifo_rd_en = rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule
